axi_resp_router: RTL and testbench
==================================

// Module: axi_resp_router
// PURPOSE
//  Response-path half of the 2-master crossbar port. Accepts R and B responses from one slave,
//  buffers each channel in a 2-entry skid FIFO and steers every beat to M0 or M1 from the ID select bit.
//  Output packets use the R_FIFO (39b) and B_FIFO (6b) packing, so they feed the per-master response FIFOs directly.
// PARAMETERS
//  IDS_BITS   8   slave-side ID width (master ID plus one select bit plus pad)
//  ID_BITS    4   master-side ID width; output ID = RID/BID[ID_BITS-1:0]
//  MSEL_BIT   4   ID bit selecting the destination: 0 -> M0, 1 -> M1
//  DATA_BITS  32  RDATA width
// PORTS
//  AXI_CLK_i    in   1             single clock
//  AXI_RST_i    in   1             asynchronous reset, active-high
//  RID_i        in   IDS_BITS      slave read ID
//  RDATA_i      in   DATA_BITS     slave read data
//  RRESP_i      in   2             slave read response
//  RLAST_i      in   1             last beat of burst
//  RVALID_i     in   1             R beat valid
//  RREADY_o     out  1             R beat accepted when RVALID_i & RREADY_o
//  BID_i        in   IDS_BITS      slave write-response ID
//  BRESP_i      in   2             write response
//  BVALID_i     in   1             B valid
//  BREADY_o     out  1             B accepted when BVALID_i & BREADY_o
//  M0_RPKT_o    out  ID_BITS+DATA_BITS+3   {id,data,resp,last} to M0
//  M0_RVALID_o  out  1             M0 R packet valid
//  M0_RREADY_i  in   1             M0 R packet taken
//  M1_RPKT_o    out  ID_BITS+DATA_BITS+3   same for M1
//  M1_RVALID_o  out  1
//  M1_RREADY_i  in   1
//  M0_BPKT_o    out  ID_BITS+2     {id,resp} to M0
//  M0_BVALID_o  out  1
//  M0_BREADY_i  in   1
//  M1_BPKT_o    out  ID_BITS+2     same for M1
//  M1_BVALID_o  out  1
//  M1_BREADY_i  in   1
//  ERR_CNT_o    out  8             saturating count of dropped bad-ID responses (R beats + B)
// BEHAVIOUR
//  - Reset: both FIFOs empty, all *VALID_o=0, RREADY_o=BREADY_o=1, packets 0, ERR_CNT_o=0. Reset mid-burst discards all entries.
//  - Each channel has a 2-entry FIFO with registered count. xREADY_o = (count<2), taken from the register,
//    with no combinational path from M*_READY_i.
//  - Push on input handshake. The head is decoded from ID[MSEL_BIT]: only that master's VALID is 1, and its PKT = head fields.
//    The other master's VALID is 0.
//  - Pop on the selected master's VALID&READY. Push and pop in the same cycle leave count unchanged (allowed when full).
//  - Latency: a beat accepted at edge k appears on M*_VALID_o after edge k. Throughput is 1 beat/cycle while the destination is ready.
//  - Ordering is strict FIFO per channel. A head waiting on a stalled master blocks the following beats, even those for the other master.
//    A beat's VALID/PKT stay stable until it is popped.
//  - Bad ID: ID bits above MSEL_BIT (IDS_BITS-1 : MSEL_BIT+1) nonzero. That head is never presented and is popped on the next edge.
//    ERR_CNT_o += 1, saturating at 255. If bad R and bad B pop together, +2 (saturating).
//  - RLAST is carried through unchanged. The router does not count bursts, and interleaved R IDs are routed per beat.
//  - R and B channels are fully independent.
// TESTING
//  1 Reset with RVALID_i=1 -> RREADY_o=BREADY_o=1, all VALID_o=0, ERR_CNT_o=0.
//  2 4-beat burst, RID=0x13, both masters ready -> M1 receives id=3 beats 1 cycle after each accept,
//    last=1 on beat 4, M0_RVALID_o never 1.
//  3 M0_RREADY_i=0, three R beats with RID=0x02 -> RREADY_o drops after 2 accepts, and the 3rd beat holds.
//    Set M0_RREADY_i=1 -> all 3 beats delivered in order.
//  4 Head for stalled M0, next beat for M1 -> M1_RVALID_o stays 0 until the M0 beat is popped.
//  5 BID=0x25 (bad) then BID=0x05 -> no B valid for the first, ERR_CNT_o=1, then M0_BPKT_o={5,resp}.
//  6 300 bad-ID R beats -> ERR_CNT_o saturates at 255. Assert AXI_RST_i mid-stream -> FIFOs empty, counter 0.

Source files
------------

// File: rtl/axi_resp_router.sv
// axi_resp_router
// Response-path half of a 2-master crossbar port. R beats and B responses from
// one slave are each buffered in a 2-entry FIFO. The head of each FIFO is
// steered to master 0 or master 1 by one select bit of its ID. Heads whose ID
// has any bit set above the select bit are dropped and counted.
module axi_resp_router #(
    parameter int IDS_BITS  = 8,
    parameter int ID_BITS   = 4,
    parameter int MSEL_BIT  = 4,
    parameter int DATA_BITS = 32
) (
    input  logic                            AXI_CLK_i,
    input  logic                            AXI_RST_i,
    // slave R channel
    input  logic [IDS_BITS-1:0]             RID_i,
    input  logic [DATA_BITS-1:0]            RDATA_i,
    input  logic [1:0]                      RRESP_i,
    input  logic                            RLAST_i,
    input  logic                            RVALID_i,
    output logic                            RREADY_o,
    // slave B channel
    input  logic [IDS_BITS-1:0]             BID_i,
    input  logic [1:0]                      BRESP_i,
    input  logic                            BVALID_i,
    output logic                            BREADY_o,
    // master 0 / master 1 R packets {id,data,resp,last}
    output logic [ID_BITS+DATA_BITS+2:0]    M0_RPKT_o,
    output logic                            M0_RVALID_o,
    input  logic                            M0_RREADY_i,
    output logic [ID_BITS+DATA_BITS+2:0]    M1_RPKT_o,
    output logic                            M1_RVALID_o,
    input  logic                            M1_RREADY_i,
    // master 0 / master 1 B packets {id,resp}
    output logic [ID_BITS+1:0]              M0_BPKT_o,
    output logic                            M0_BVALID_o,
    input  logic                            M0_BREADY_i,
    output logic [ID_BITS+1:0]              M1_BPKT_o,
    output logic                            M1_BVALID_o,
    input  logic                            M1_BREADY_i,
    // saturating count of dropped bad-ID responses
    output logic [7:0]                      ERR_CNT_o
);

    // Entries keep the full slave-side ID so the head can be decoded on the way out.
    localparam int RENT_BITS = IDS_BITS + DATA_BITS + 3;
    localparam int RPKT_BITS = ID_BITS + DATA_BITS + 3;
    localparam int BENT_BITS = IDS_BITS + 2;
    localparam int BPKT_BITS = ID_BITS + 2;

    // ------------------------------------------------------------------
    // R channel FIFO state and head decode
    // ------------------------------------------------------------------
    logic [RENT_BITS-1:0] r_rMem [2];
    logic                 r_rWrPtr;
    logic                 r_rRdPtr;
    logic [1:0]           r_rCount;

    logic [RENT_BITS-1:0] w_rHead;
    logic [IDS_BITS-1:0]  w_rHeadId;
    logic [RPKT_BITS-1:0] w_rHeadPkt;
    logic                 w_rNotEmpty;
    logic                 w_rHeadBad;
    logic                 w_rHeadSel;
    logic                 w_rPush;
    logic                 w_rPop;
    logic                 w_rBadPop;

    // ------------------------------------------------------------------
    // B channel FIFO state and head decode
    // ------------------------------------------------------------------
    logic [BENT_BITS-1:0] r_bMem [2];
    logic                 r_bWrPtr;
    logic                 r_bRdPtr;
    logic [1:0]           r_bCount;

    logic [BENT_BITS-1:0] w_bHead;
    logic [IDS_BITS-1:0]  w_bHeadId;
    logic [BPKT_BITS-1:0] w_bHeadPkt;
    logic                 w_bNotEmpty;
    logic                 w_bHeadBad;
    logic                 w_bHeadSel;
    logic                 w_bPush;
    logic                 w_bPop;
    logic                 w_bBadPop;

    // ------------------------------------------------------------------
    // Error counter
    // ------------------------------------------------------------------
    logic [7:0]           r_errCnt;
    logic [1:0]           w_errInc;
    logic [8:0]           w_errSum;

    // Ready depends only on the registered occupancy, so master-side ready
    // never reaches the slave-side ready combinationally.
    assign RREADY_o = (r_rCount != 2'd2);
    assign BREADY_o = (r_bCount != 2'd2);

    assign w_rPush = RVALID_i & RREADY_o;
    assign w_bPush = BVALID_i & BREADY_o;

    // Decode the R head: destination from the select bit, bad if any bit above it is set.
    always_comb begin
        w_rNotEmpty = (r_rCount != 2'd0);
        w_rHead     = r_rMem[r_rRdPtr];
        w_rHeadId   = w_rHead[RENT_BITS-1 -: IDS_BITS];
        w_rHeadBad  = ((w_rHeadId >> (MSEL_BIT + 1)) != '0);
        w_rHeadSel  = w_rHeadId[MSEL_BIT];
        w_rHeadPkt  = {w_rHeadId[ID_BITS-1:0], w_rHead[DATA_BITS+2:0]};
        M0_RVALID_o = w_rNotEmpty & ~w_rHeadBad & ~w_rHeadSel;
        M1_RVALID_o = w_rNotEmpty & ~w_rHeadBad &  w_rHeadSel;
        M0_RPKT_o   = M0_RVALID_o ? w_rHeadPkt : '0;
        M1_RPKT_o   = M1_RVALID_o ? w_rHeadPkt : '0;
        w_rBadPop   = w_rNotEmpty & w_rHeadBad;
        w_rPop      = w_rBadPop | (M0_RVALID_o & M0_RREADY_i) | (M1_RVALID_o & M1_RREADY_i);
    end

    // Decode the B head the same way as the R head.
    always_comb begin
        w_bNotEmpty = (r_bCount != 2'd0);
        w_bHead     = r_bMem[r_bRdPtr];
        w_bHeadId   = w_bHead[BENT_BITS-1 -: IDS_BITS];
        w_bHeadBad  = ((w_bHeadId >> (MSEL_BIT + 1)) != '0);
        w_bHeadSel  = w_bHeadId[MSEL_BIT];
        w_bHeadPkt  = {w_bHeadId[ID_BITS-1:0], w_bHead[1:0]};
        M0_BVALID_o = w_bNotEmpty & ~w_bHeadBad & ~w_bHeadSel;
        M1_BVALID_o = w_bNotEmpty & ~w_bHeadBad &  w_bHeadSel;
        M0_BPKT_o   = M0_BVALID_o ? w_bHeadPkt : '0;
        M1_BPKT_o   = M1_BVALID_o ? w_bHeadPkt : '0;
        w_bBadPop   = w_bNotEmpty & w_bHeadBad;
        w_bPop      = w_bBadPop | (M0_BVALID_o & M0_BREADY_i) | (M1_BVALID_o & M1_BREADY_i);
    end

    // R FIFO pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge AXI_CLK_i or posedge AXI_RST_i) begin
        if (AXI_RST_i) begin
            r_rWrPtr <= 1'b0;
            r_rRdPtr <= 1'b0;
            r_rCount <= 2'd0;
        end else begin
            if (w_rPush) begin
                r_rWrPtr <= ~r_rWrPtr;
            end
            if (w_rPop) begin
                r_rRdPtr <= ~r_rRdPtr;
            end
            case ({w_rPush, w_rPop})
                2'b10:   r_rCount <= r_rCount + 2'd1;
                2'b01:   r_rCount <= r_rCount - 2'd1;
                default: r_rCount <= r_rCount;
            endcase
        end
    end

    // R FIFO storage, cleared on reset so idle packets read back as zero.
    always_ff @(posedge AXI_CLK_i or posedge AXI_RST_i) begin
        if (AXI_RST_i) begin
            for (int i = 0; i < 2; i++) begin
                r_rMem[i] <= '0;
            end
        end else if (w_rPush) begin
            r_rMem[r_rWrPtr] <= {RID_i, RDATA_i, RRESP_i, RLAST_i};
        end
    end

    // B FIFO pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge AXI_CLK_i or posedge AXI_RST_i) begin
        if (AXI_RST_i) begin
            r_bWrPtr <= 1'b0;
            r_bRdPtr <= 1'b0;
            r_bCount <= 2'd0;
        end else begin
            if (w_bPush) begin
                r_bWrPtr <= ~r_bWrPtr;
            end
            if (w_bPop) begin
                r_bRdPtr <= ~r_bRdPtr;
            end
            case ({w_bPush, w_bPop})
                2'b10:   r_bCount <= r_bCount + 2'd1;
                2'b01:   r_bCount <= r_bCount - 2'd1;
                default: r_bCount <= r_bCount;
            endcase
        end
    end

    // B FIFO storage, cleared on reset so idle packets read back as zero.
    always_ff @(posedge AXI_CLK_i or posedge AXI_RST_i) begin
        if (AXI_RST_i) begin
            for (int i = 0; i < 2; i++) begin
                r_bMem[i] <= '0;
            end
        end else if (w_bPush) begin
            r_bMem[r_bWrPtr] <= {BID_i, BRESP_i};
        end
    end

    // Count of drops this cycle (0..2) added with saturation at 255.
    always_comb begin
        w_errInc = {1'b0, w_rBadPop} + {1'b0, w_bBadPop};
        w_errSum = {1'b0, r_errCnt} + {7'b0, w_errInc};
    end

    // Error counter register; holds at 255 once reached.
    always_ff @(posedge AXI_CLK_i or posedge AXI_RST_i) begin
        if (AXI_RST_i) begin
            r_errCnt <= 8'd0;
        end else if (w_errSum[8]) begin
            r_errCnt <= 8'hFF;
        end else begin
            r_errCnt <= w_errSum[7:0];
        end
    end

    assign ERR_CNT_o = r_errCnt;

endmodule

// File: tb/tb_axi_resp_router.sv
// tb_axi_resp_router
// Drivers push every accepted beat into a per-channel queue of pending beats;
// a monitor on the falling edge checks what the router presents against the
// head of that queue and retires it when the selected master takes it.
module tb_axi_resp_router;

    localparam int IDS_BITS  = 8;
    localparam int ID_BITS   = 4;
    localparam int MSEL_BIT  = 4;
    localparam int DATA_BITS = 32;
    localparam int RPKT_BITS = ID_BITS + DATA_BITS + 3;
    localparam int BPKT_BITS = ID_BITS + 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [IDS_BITS-1:0]   RID_i = '0;
    logic [DATA_BITS-1:0]  RDATA_i = '0;
    logic [1:0]            RRESP_i = '0;
    logic                  RLAST_i = 1'b0;
    logic                  RVALID_i = 1'b0;
    logic                  RREADY_o;
    logic [IDS_BITS-1:0]   BID_i = '0;
    logic [1:0]            BRESP_i = '0;
    logic                  BVALID_i = 1'b0;
    logic                  BREADY_o;
    logic [RPKT_BITS-1:0]  M0_RPKT_o, M1_RPKT_o;
    logic                  M0_RVALID_o, M1_RVALID_o;
    logic                  M0_RREADY_i = 1'b1, M1_RREADY_i = 1'b1;
    logic [BPKT_BITS-1:0]  M0_BPKT_o, M1_BPKT_o;
    logic                  M0_BVALID_o, M1_BVALID_o;
    logic                  M0_BREADY_i = 1'b1, M1_BREADY_i = 1'b1;
    logic [7:0]            ERR_CNT_o;

    axi_resp_router #(
        .IDS_BITS(IDS_BITS), .ID_BITS(ID_BITS), .MSEL_BIT(MSEL_BIT), .DATA_BITS(DATA_BITS)
    ) dut (
        .AXI_CLK_i(clk),       .AXI_RST_i(rst),
        .RID_i(RID_i),         .RDATA_i(RDATA_i),     .RRESP_i(RRESP_i),
        .RLAST_i(RLAST_i),     .RVALID_i(RVALID_i),   .RREADY_o(RREADY_o),
        .BID_i(BID_i),         .BRESP_i(BRESP_i),     .BVALID_i(BVALID_i),
        .BREADY_o(BREADY_o),
        .M0_RPKT_o(M0_RPKT_o), .M0_RVALID_o(M0_RVALID_o), .M0_RREADY_i(M0_RREADY_i),
        .M1_RPKT_o(M1_RPKT_o), .M1_RVALID_o(M1_RVALID_o), .M1_RREADY_i(M1_RREADY_i),
        .M0_BPKT_o(M0_BPKT_o), .M0_BVALID_o(M0_BVALID_o), .M0_BREADY_i(M0_BREADY_i),
        .M1_BPKT_o(M1_BPKT_o), .M1_BVALID_o(M1_BVALID_o), .M1_BREADY_i(M1_BREADY_i),
        .ERR_CNT_o(ERR_CNT_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDS_BITS-1:0]  id;
        logic [DATA_BITS-1:0] data;
        logic [1:0]           resp;
        logic                 last;
    } rBeat_t;

    typedef struct {
        logic [IDS_BITS-1:0] id;
        logic [1:0]          resp;
    } bBeat_t;

    // Reference state: beats accepted but not yet delivered or dropped, and the drop count.
    rBeat_t rQ[$];
    bBeat_t bQ[$];
    int     modelErr = 0;

    int numVectors = 0;
    int numMiscompares = 0;
    logic stimDone = 1'b0;

    // Compare one observed value with its expected value.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        numVectors++;
        if (actual !== expected) begin
            numMiscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // A bound on waiting for the DUT expired.
    task automatic timeoutFail(input string name);
        numVectors++;
        numMiscompares++;
        $display("[TB] FAIL %s: timeout waiting for ready at %0t", name, $time);
    endtask

    function automatic logic isBad(input logic [IDS_BITS-1:0] id);
        return (int'(id) / (2 ** (MSEL_BIT + 1))) != 0;
    endfunction

    function automatic logic goesToM1(input logic [IDS_BITS-1:0] id);
        return ((int'(id) / (2 ** MSEL_BIT)) % 2) == 1;
    endfunction

    function automatic logic [ID_BITS-1:0] masterId(input logic [IDS_BITS-1:0] id);
        return ID_BITS'(int'(id) % (2 ** ID_BITS));
    endfunction

    // Mix of M0, M1 and bad IDs.
    function automatic logic [IDS_BITS-1:0] randId();
        int kind = $urandom_range(0, 9);
        logic [IDS_BITS-1:0] id;
        if (kind < 4)      id = {3'b000, 1'b0, 4'($urandom)};
        else if (kind < 8) id = {3'b000, 1'b1, 4'($urandom)};
        else               id = {3'($urandom_range(1, 7)), 5'($urandom)};
        return id;
    endfunction

    // Present one R beat from posedge+1 until accepted; record it at the accepting edge.
    task automatic applyStimulusR(input logic [IDS_BITS-1:0] id, input logic [DATA_BITS-1:0] data,
                                  input logic [1:0] resp, input logic last);
        int waited = 0;
        rBeat_t b;
        RID_i = id; RDATA_i = data; RRESP_i = resp; RLAST_i = last; RVALID_i = 1'b1;
        @(negedge clk);
        while (!RREADY_o && waited < 1000) begin
            waited++;
            @(negedge clk);
        end
        if (!RREADY_o) begin
            timeoutFail("R_accept");
            RVALID_i = 1'b0;
            return;
        end
        @(posedge clk);
        b.id = id; b.data = data; b.resp = resp; b.last = last;
        rQ.push_back(b);
        #1;
    endtask

    // Present one B response from posedge+1 until accepted; record it at the accepting edge.
    task automatic applyStimulusB(input logic [IDS_BITS-1:0] id, input logic [1:0] resp);
        int waited = 0;
        bBeat_t b;
        BID_i = id; BRESP_i = resp; BVALID_i = 1'b1;
        @(negedge clk);
        while (!BREADY_o && waited < 1000) begin
            waited++;
            @(negedge clk);
        end
        if (!BREADY_o) begin
            timeoutFail("B_accept");
            BVALID_i = 1'b0;
            return;
        end
        @(posedge clk);
        b.id = id; b.resp = resp;
        bQ.push_back(b);
        #1;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare presented outputs to the head of each pending queue, then retire heads
    // that the coming edge will pop (taken by the selected master, or dropped as bad).
    rBeat_t rh;
    bBeat_t bh;
    int     drops;
    always @(negedge clk) begin
        if (rst) begin
            rQ.delete();
            bQ.delete();
            modelErr = 0;
        end else begin
            drops = 0;
            checkOutput("ERR_CNT", ERR_CNT_o, modelErr);
            checkOutput("RREADY", RREADY_o, rQ.size() < 2);
            checkOutput("BREADY", BREADY_o, bQ.size() < 2);
            if (rQ.size() == 0) begin
                checkOutput("M0_RVALID_idle", M0_RVALID_o, 0);
                checkOutput("M1_RVALID_idle", M1_RVALID_o, 0);
            end else begin
                rh = rQ[0];
                checkOutput("M0_RVALID", M0_RVALID_o, !isBad(rh.id) && !goesToM1(rh.id));
                checkOutput("M1_RVALID", M1_RVALID_o, !isBad(rh.id) &&  goesToM1(rh.id));
                if (isBad(rh.id)) begin
                    void'(rQ.pop_front());
                    drops++;
                end else if (!goesToM1(rh.id)) begin
                    checkOutput("M0_RPKT", M0_RPKT_o, {masterId(rh.id), rh.data, rh.resp, rh.last});
                    if (M0_RREADY_i) void'(rQ.pop_front());
                end else begin
                    checkOutput("M1_RPKT", M1_RPKT_o, {masterId(rh.id), rh.data, rh.resp, rh.last});
                    if (M1_RREADY_i) void'(rQ.pop_front());
                end
            end
            if (bQ.size() == 0) begin
                checkOutput("M0_BVALID_idle", M0_BVALID_o, 0);
                checkOutput("M1_BVALID_idle", M1_BVALID_o, 0);
            end else begin
                bh = bQ[0];
                checkOutput("M0_BVALID", M0_BVALID_o, !isBad(bh.id) && !goesToM1(bh.id));
                checkOutput("M1_BVALID", M1_BVALID_o, !isBad(bh.id) &&  goesToM1(bh.id));
                if (isBad(bh.id)) begin
                    void'(bQ.pop_front());
                    drops++;
                end else if (!goesToM1(bh.id)) begin
                    checkOutput("M0_BPKT", M0_BPKT_o, {masterId(bh.id), bh.resp});
                    if (M0_BREADY_i) void'(bQ.pop_front());
                end else begin
                    checkOutput("M1_BPKT", M1_BPKT_o, {masterId(bh.id), bh.resp});
                    if (M1_BREADY_i) void'(bQ.pop_front());
                end
            end
            modelErr = (modelErr + drops > 255) ? 255 : modelErr + drops;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by a randomized phase, saturation and mid-stream reset.
    initial begin
        // Reset with valid inputs asserted.
        rst = 1'b1;
        RVALID_i = 1'b1; RID_i = 8'h13; BVALID_i = 1'b1; BID_i = 8'h05;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_RREADY", RREADY_o, 1);
        checkOutput("rst_BREADY", BREADY_o, 1);
        checkOutput("rst_valids", {M0_RVALID_o, M1_RVALID_o, M0_BVALID_o, M1_BVALID_o}, 0);
        checkOutput("rst_ERR", ERR_CNT_o, 0);
        checkOutput("rst_RPKT", {M0_RPKT_o, M1_RPKT_o} != 0, 0);
        checkOutput("rst_BPKT", {M0_BPKT_o, M1_BPKT_o}, 0);
        RVALID_i = 1'b0; BVALID_i = 1'b0;
        rst = 1'b0;
        idleCycles(2);

        // 4-beat burst to M1 with both masters ready.
        for (int i = 0; i < 4; i++) applyStimulusR(8'h13, $urandom, 2'(i), i == 3);
        RVALID_i = 1'b0;
        idleCycles(3);

        // M0 stalled: two beats fill the FIFO, the third waits until M0 resumes.
        M0_RREADY_i = 1'b0;
        fork
            begin
                for (int i = 0; i < 3; i++) applyStimulusR(8'h02, $urandom, 2'b00, i == 2);
                RVALID_i = 1'b0;
            end
            begin
                idleCycles(4);
                checkOutput("stall_RREADY", RREADY_o, 0);
                idleCycles(4);
                M0_RREADY_i = 1'b1;
            end
        join
        idleCycles(4);

        // Head-of-line blocking: M0 head stalled, M1 beat behind it must wait.
        M0_RREADY_i = 1'b0;
        applyStimulusR(8'h01, 32'hA5A5_0001, 2'b01, 1'b1);
        applyStimulusR(8'h11, 32'h5A5A_0011, 2'b10, 1'b1);
        RVALID_i = 1'b0;
        idleCycles(5);
        checkOutput("hol_M1_RVALID", M1_RVALID_o, 0);
        M0_RREADY_i = 1'b1;
        idleCycles(4);

        // Bad B then good B to M0.
        applyStimulusB(8'h25, 2'b10);
        applyStimulusB(8'h05, 2'b01);
        BVALID_i = 1'b0;
        idleCycles(3);
        checkOutput("bad_B_ERR", ERR_CNT_o, 1);

        // Randomized traffic on both channels with random master backpressure.
        fork
            begin
                fork
                    begin
                        for (int i = 0; i < 400; i++) begin
                            if ($urandom_range(0, 3) == 0) begin
                                RVALID_i = 1'b0;
                                idleCycles(1);
                            end else begin
                                applyStimulusR(randId(), $urandom, 2'($urandom), 1'($urandom));
                            end
                        end
                        RVALID_i = 1'b0;
                    end
                    begin
                        for (int i = 0; i < 300; i++) begin
                            if ($urandom_range(0, 2) == 0) begin
                                BVALID_i = 1'b0;
                                idleCycles(1);
                            end else begin
                                applyStimulusB(randId(), 2'($urandom));
                            end
                        end
                        BVALID_i = 1'b0;
                    end
                join
                stimDone = 1'b1;
            end
            begin
                while (!stimDone) begin
                    M0_RREADY_i = ($urandom_range(0, 9) < 7);
                    M1_RREADY_i = ($urandom_range(0, 9) < 7);
                    M0_BREADY_i = ($urandom_range(0, 9) < 7);
                    M1_BREADY_i = ($urandom_range(0, 9) < 7);
                    idleCycles(1);
                end
            end
        join
        M0_RREADY_i = 1'b1; M1_RREADY_i = 1'b1; M0_BREADY_i = 1'b1; M1_BREADY_i = 1'b1;
        idleCycles(10);

        // 300 bad R beats saturate the counter.
        for (int i = 0; i < 300; i++) applyStimulusR({3'($urandom_range(1, 7)), 5'($urandom)}, $urandom, 2'b00, 1'b1);
        RVALID_i = 1'b0;
        idleCycles(4);
        checkOutput("err_saturate", ERR_CNT_o, 255);

        // Reset with beats pending for a stalled M0.
        M0_RREADY_i = 1'b0; M0_BREADY_i = 1'b0;
        applyStimulusR(8'h03, 32'h1111_2222, 2'b00, 1'b0);
        applyStimulusR(8'h04, 32'h3333_4444, 2'b00, 1'b1);
        RVALID_i = 1'b0;
        applyStimulusB(8'h02, 2'b11);
        BVALID_i = 1'b0;
        idleCycles(2);
        rst = 1'b1;
        idleCycles(2);
        checkOutput("midrst_RREADY", RREADY_o, 1);
        checkOutput("midrst_BREADY", BREADY_o, 1);
        checkOutput("midrst_valids", {M0_RVALID_o, M1_RVALID_o, M0_BVALID_o, M1_BVALID_o}, 0);
        checkOutput("midrst_ERR", ERR_CNT_o, 0);
        rst = 1'b0;
        M0_RREADY_i = 1'b1; M0_BREADY_i = 1'b1;
        idleCycles(5);

        $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
        $finish;
    end

endmodule
